// File: rtl/game_pkg.sv
// Shared types and constants for the collision arbiter and its neighbours.
package game_pkg;

    typedef enum logic [1:0] {
        ARMED_ST    = 2'd0,
        ISSUE_ST    = 2'd1,
        COOLDOWN_ST = 2'd2
    } arb_state_e;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;

    localparam int EDGE_W = 4;
    localparam int CNT_W  = 4;

    // Builds a per-source edge code from individual edge flags.
    function automatic logic [EDGE_W-1:0] make_edge(input logic bottom, input logic right,
                                                    input logic top, input logic left);
        logic [EDGE_W-1:0] code;
        code              = '0;
        code[EDGE_BOTTOM] = bottom;
        code[EDGE_RIGHT]  = right;
        code[EDGE_TOP]    = top;
        code[EDGE_LEFT]   = left;
        return code;
    endfunction

endpackage

// File: rtl/collision_arbiter_if.sv
// Bundle between the hit detectors (master) and the collision arbiter (slave).
interface collision_arbiter_if
    import game_pkg::*;
#(
    parameter int NUM_SRC = 4
);
    localparam int IDX_W = $clog2(NUM_SRC);

    logic                      startOfFrame;
    logic                      enable;
    logic [NUM_SRC-1:0]        src_req;
    logic [EDGE_W*NUM_SRC-1:0] src_edge;
    logic                      collision;
    logic [EDGE_W-1:0]         HitEdgeCode;
    logic [IDX_W-1:0]          grant_idx;
    logic [NUM_SRC-1:0]        lost_mask;

    modport master (
        output startOfFrame, enable, src_req, src_edge,
        input  collision, HitEdgeCode, grant_idx, lost_mask
    );

    modport slave (
        input  startOfFrame, enable, src_req, src_edge,
        output collision, HitEdgeCode, grant_idx, lost_mask
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so ptr_i is bit 0, take the lowest set bit,
// then rotate the chosen offset back to an absolute source index.
module rr_priority_pick #(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    logic [NUM_SRC-1:0] req_rot;
    logic [IDX_W-1:0]   offset;

    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_rot[i] = req_i[(i + int'(ptr_i)) % NUM_SRC];
        end
    end

    always_comb begin
        offset  = '0;
        valid_o = |req_rot;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    always_comb begin
        int sum;
        sum = int'(offset) + int'(ptr_i);
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        winner_o = IDX_W'(sum);
    end

endmodule

// File: rtl/collision_arbiter.sv
// Grants one collision per cooldown window to the mover, round-robin among
// simultaneous requesters, and reports which requests were dropped each frame.
module collision_arbiter
    import game_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input logic                clk,
    input logic                resetN,
    collision_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_SRC);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] acc_q, acc_d;
    logic [NUM_SRC-1:0] lost_mask_q, lost_mask_d;
    logic               collision_q, collision_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;

    logic [IDX_W-1:0]   winner;
    logic               winner_valid;
    logic               grant;
    logic               last_frame;
    logic [NUM_SRC-1:0] lost_this;

    rr_priority_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req_i    (bus.src_req),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .valid_o  (winner_valid)
    );

    assign grant      = (state_q == ARMED_ST) && bus.enable && winner_valid;
    assign last_frame = (state_q == COOLDOWN_ST) && bus.enable && bus.startOfFrame
                        && (cnt_q == CNT_W'(1));

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ARMED_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMED_ST:    if (grant) state_d = ISSUE_ST;
            ISSUE_ST:    state_d = bus.enable ? COOLDOWN_ST : ARMED_ST;
            COOLDOWN_ST: if (!bus.enable || last_frame) state_d = ARMED_ST;
            default:     state_d = ARMED_ST;
        endcase
    end

    always_comb begin
        collision_d = grant;
        edge_d      = edge_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        lost_this   = '0;

        if (grant) begin
            edge_d      = bus.src_edge[EDGE_W*int'(winner) +: EDGE_W];
            grant_idx_d = winner;
            lost_this   = bus.src_req & ~(NUM_SRC'(1) << winner);
        end

        case (state_q)
            ISSUE_ST: begin
                rr_ptr_d = (grant_idx_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx_q + 1'b1;
                cnt_d    = CNT_W'(COOLDOWN_FRAMES);
            end
            COOLDOWN_ST: begin
                if (!bus.enable) begin
                    cnt_d = '0;
                end else begin
                    lost_this = bus.src_req;
                    if (bus.startOfFrame) cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase

        // The frame snapshot takes the accumulator as it stood before this cycle.
        if (bus.startOfFrame) begin
            lost_mask_d = acc_q;
            acc_d       = lost_this;
        end else begin
            lost_mask_d = lost_mask_q;
            acc_d       = acc_q | lost_this;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision_q <= 1'b0;
            edge_q      <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            lost_mask_q <= '0;
        end else begin
            collision_q <= collision_d;
            edge_q      <= edge_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            lost_mask_q <= lost_mask_d;
        end
    end

    assign bus.collision   = collision_q;
    assign bus.HitEdgeCode = edge_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.lost_mask   = lost_mask_q;

endmodule
